alarm_player: RTL and testbench

ALARM_PLAYER -- requirements
Module: alarm_player

---
 rtl/alarm_player.sv | 170 +++++++++++++++++
 tb/tb_alarm_player.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/alarm_player.sv
// Alarm melody player: plays a 16-entry ROM tune as a square wave on a piezo until silenced.
// alarm_do carries the alarm block's "do" fire level; "do" itself is a reserved word.
module alarm_player #(
    parameter int CLK_HZ    = 1_000_000,
    parameter int BEAT_CYC  = 250_000,
    parameter int GAP_CYC   = 25_000,
    parameter int MAX_LOOPS = 0
) (
    input  logic       newclk,
    input  logic       rst_n,
    input  logic       alarm_do,
    input  logic       switch,
    output logic       buzzer,
    output logic       playing,
    output logic [3:0] note_idx
);

    // Lowest tone (262 Hz) has the longest half-period.
    localparam int HP_MAX  = (CLK_HZ + 262) / (2 * 262);
    localparam int DUR_MAX = (4 * BEAT_CYC > GAP_CYC) ? 4 * BEAT_CYC : GAP_CYC;
    localparam int DW      = $clog2(DUR_MAX + 1);
    localparam int PW      = $clog2(HP_MAX + 1);
    localparam int LW      = 16;

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    state_t          state;
    logic            do_q;
    logic [DW-1:0]   dur;
    logic [PW-1:0]   phase;
    logic [LW-1:0]   loops;

    logic [4:0]      entry;
    logic [2:0]      tone;
    logic [1:0]      len;
    logic [PW-1:0]   hp;
    logic [LW-1:0]   loops_nx;
    logic            start;
    logic            stop;

    function automatic logic [4:0] melody(input logic [3:0] i);
        case (i)
            4'd0, 4'd1:   melody = 5'b001_00;
            4'd2, 4'd3:   melody = 5'b101_00;
            4'd4, 4'd5:   melody = 5'b110_00;
            4'd6:         melody = 5'b101_01;
            4'd7, 4'd8:   melody = 5'b100_00;
            4'd9, 4'd10:  melody = 5'b011_00;
            4'd11, 4'd12: melody = 5'b010_00;
            4'd13:        melody = 5'b001_01;
            default:      melody = 5'b000_00;
        endcase
    endfunction

    function automatic logic [PW-1:0] half_period(input logic [2:0] t);
        int f;
        case (t)
            3'd1:    f = 262;
            3'd2:    f = 294;
            3'd3:    f = 330;
            3'd4:    f = 349;
            3'd5:    f = 392;
            3'd6:    f = 440;
            3'd7:    f = 494;
            default: f = 0;
        endcase
        if (f == 0)
            half_period = '0;
        else
            half_period = PW'((CLK_HZ + f) / (2 * f));
    endfunction

    function automatic logic [DW-1:0] play_last(input logic [1:0] l);
        play_last = DW'((int'(l) + 1) * BEAT_CYC - 1);
    endfunction

    function automatic logic [LW-1:0] sat_inc(input logic [LW-1:0] v);
        sat_inc = (&v) ? v : v + 1'b1;
    endfunction

    assign entry    = melody(note_idx);
    assign tone     = entry[4:2];
    assign len      = entry[1:0];
    assign hp       = half_period(tone);
    assign loops_nx = sat_inc(loops);
    assign start    = alarm_do && !do_q;
    // A stop beats every note/gap transition evaluated in the same cycle.
    assign stop     = switch || (!alarm_do && state != IDLE);

    always_ff @(posedge newclk) begin
        if (!rst_n) begin
            state    <= IDLE;
            do_q     <= 1'b0;
            dur      <= '0;
            phase    <= '0;
            loops    <= '0;
            buzzer   <= 1'b0;
            playing  <= 1'b0;
            note_idx <= '0;
        end else begin
            do_q <= alarm_do;
            if (stop) begin
                state    <= IDLE;
                dur      <= '0;
                phase    <= '0;
                loops    <= '0;
                buzzer   <= 1'b0;
                playing  <= 1'b0;
                note_idx <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state    <= PLAY;
                            playing  <= 1'b1;
                            note_idx <= '0;
                            loops    <= '0;
                            dur      <= '0;
                            phase    <= '0;
                            buzzer   <= 1'b0;
                        end
                    end
                    PLAY: begin
                        if (dur == play_last(len)) begin
                            state  <= GAP;
                            dur    <= '0;
                            phase  <= '0;
                            buzzer <= 1'b0;
                        end else begin
                            dur <= dur + 1'b1;
                            if (tone == 3'd0) begin
                                phase  <= '0;
                                buzzer <= 1'b0;
                            end else if (phase == hp - 1'b1) begin
                                phase  <= '0;
                                buzzer <= ~buzzer;
                            end else begin
                                phase <= phase + 1'b1;
                            end
                        end
                    end
                    GAP: begin
                        if (dur == DW'(GAP_CYC - 1)) begin
                            dur    <= '0;
                            phase  <= '0;
                            buzzer <= 1'b0;
                            if (note_idx == 4'd15) begin
                                note_idx <= '0;
                                loops    <= loops_nx;
                                if (MAX_LOOPS != 0 && loops_nx == LW'(MAX_LOOPS)) begin
                                    state   <= IDLE;
                                    playing <= 1'b0;
                                end else begin
                                    state <= PLAY;
                                end
                            end else begin
                                note_idx <= note_idx + 1'b1;
                                state    <= PLAY;
                            end
                        end else begin
                            dur <= dur + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alarm_player.sv
// Scoreboard bench for alarm_player: per-note segments (length, first buzzer rise, high cycles)
// are queued from a melody table and compared as the DUT leaves each note.
module tb_alarm_player;

    localparam int CLK_HZ = 20_000;
    localparam int BEAT   = 200;
    localparam int GAP    = 20;

    logic       newclk = 1'b0;
    logic       rst_n;
    logic       alarm_do;
    logic       switch;
    logic       a_buz, a_play;
    logic [3:0] a_note;
    logic       b_buz, b_play;
    logic [3:0] b_note;

    always #5 newclk = ~newclk;

    alarm_player #(.CLK_HZ(CLK_HZ), .BEAT_CYC(BEAT), .GAP_CYC(GAP), .MAX_LOOPS(2)) u_a (
        .newclk(newclk), .rst_n(rst_n), .alarm_do(alarm_do), .switch(switch),
        .buzzer(a_buz), .playing(a_play), .note_idx(a_note)
    );

    alarm_player #(.CLK_HZ(CLK_HZ), .BEAT_CYC(BEAT), .GAP_CYC(GAP), .MAX_LOOPS(0)) u_b (
        .newclk(newclk), .rst_n(rst_n), .alarm_do(alarm_do), .switch(switch),
        .buzzer(b_buz), .playing(b_play), .note_idx(b_note)
    );

    typedef struct {
        int idx;
        int len;
        int first;
        int high;
    } seg_t;

    seg_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    int tone_t[16] = '{1, 1, 5, 5, 6, 6, 5, 4, 4, 3, 3, 2, 2, 1, 0, 0};
    int len_t[16]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    int freq[8]    = '{0, 262, 294, 330, 349, 392, 440, 494};

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // lim caps the segment when a stop cuts the note short.
    task automatic push_seg(input int idx, input int lim);
        seg_t s;
        int n, full, l, pl, hp;
        n    = (len_t[idx] + 1) * BEAT;
        full = n + GAP;
        l    = (lim < full) ? lim : full;
        pl   = (l < n) ? l : n;
        s.idx   = idx;
        s.len   = l;
        s.first = 0;
        s.high  = 0;
        if (tone_t[idx] != 0) begin
            hp = (CLK_HZ + freq[tone_t[idx]]) / (2 * freq[tone_t[idx]]);
            if (hp < pl) s.first = hp;
            for (int c = 0; c < pl; c++)
                if (((c / hp) % 2) == 1) s.high++;
        end
        sbq.push_back(s);
    endtask

    int   act = 0, cur_idx = 0, cnt = 0, first = 0, high = 0;
    seg_t e;

    always @(negedge newclk) begin
        if (act != 0 && (!a_play || int'(a_note) != cur_idx)) begin
            if (sbq.size() == 0) begin
                chk("sb_unexpected", cur_idx, -1);
            end else begin
                e = sbq.pop_front();
                chk("seg_idx", cur_idx, e.idx);
                chk("seg_len", cnt, e.len);
                chk("seg_first", first, e.first);
                chk("seg_high", high, e.high);
            end
            act = 0;
        end
        if (a_play && act == 0) begin
            act = 1; cur_idx = int'(a_note); cnt = 0; first = 0; high = 0;
        end
        if (act != 0) begin
            if (a_buz && high == 0) first = cnt;
            if (a_buz) high++;
            cnt++;
        end
    end

    initial begin
        int n;
        rst_n = 1'b0; alarm_do = 1'b0; switch = 1'b0;
        repeat (3) @(negedge newclk);
        chk("rst_play", a_play, 0);
        chk("rst_note", a_note, 0);
        chk("rst_buz", a_buz, 0);
        chk("rst_b_play", b_play, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge newclk);
        chk("idle_play", a_play, 0);

        // Two complete loops, then auto-stop on the MAX_LOOPS=2 instance.
        for (int l = 0; l < 2; l++)
            for (int i = 0; i < 16; i++) push_seg(i, 1 << 30);
        alarm_do = 1'b1;
        @(negedge newclk);
        chk("start_play", a_play, 1);
        chk("start_note", a_note, 0);
        chk("start_buz", a_buz, 0);
        n = 0;
        while (a_play && n < 10000) begin @(negedge newclk); n++; end
        chk("loops_stop", a_play, 0);
        chk("loops_note", a_note, 0);
        chk("endless_play", b_play, 1);
        chk("endless_note", b_note, 0);
        repeat (5) @(negedge newclk);
        chk("hold_no_restart", a_play, 0);
        alarm_do = 1'b0;
        @(negedge newclk);
        chk("do_fall_play", b_play, 0);
        chk("do_fall_note", b_note, 0);

        // switch in the middle of entry 3's tone
        for (int i = 0; i < 3; i++) push_seg(i, 1 << 30);
        push_seg(3, 51);
        alarm_do = 1'b1;
        n = 0;
        while (!(a_play && a_note == 4'd3) && n < 5000) begin @(negedge newclk); n++; end
        chk("reach_entry3", a_note, 3);
        repeat (50) @(negedge newclk);
        switch = 1'b1;
        @(negedge newclk);
        chk("sw_play", a_play, 0);
        chk("sw_note", a_note, 0);
        chk("sw_buz", a_buz, 0);
        switch = 1'b0;
        repeat (10) @(negedge newclk);
        chk("sw_hold_idle", a_play, 0);

        // do falls inside the gap after entry 0
        alarm_do = 1'b0;
        @(negedge newclk);
        push_seg(0, 206);
        alarm_do = 1'b1;
        @(negedge newclk);
        chk("restart_play", a_play, 1);
        repeat (205) @(negedge newclk);
        chk("gap_buz", a_buz, 0);
        alarm_do = 1'b0;
        @(negedge newclk);
        chk("gap_fall_play", a_play, 0);

        // rising do with switch held in the same cycle
        alarm_do = 1'b1; switch = 1'b1;
        @(negedge newclk);
        chk("rise_sw_play", a_play, 0);
        switch = 1'b0;
        repeat (3) @(negedge newclk);
        chk("rise_sw_hold", a_play, 0);

        // reset in the middle of a note with do held high
        alarm_do = 1'b0;
        @(negedge newclk);
        push_seg(0, 120);
        alarm_do = 1'b1;
        @(negedge newclk);
        repeat (119) @(negedge newclk);
        rst_n = 1'b0;
        @(negedge newclk);
        chk("midrst_play", a_play, 0);
        chk("midrst_note", a_note, 0);
        chk("midrst_buz", a_buz, 0);
        chk("midrst_b_play", b_play, 0);
        rst_n = 1'b1;
        push_seg(0, 1);
        @(negedge newclk);
        chk("rst_rel_play", a_play, 1);
        chk("rst_rel_note", a_note, 0);
        chk("rst_rel_buz", a_buz, 0);
        switch = 1'b1;
        @(negedge newclk);
        switch = 1'b0;
        chk("final_stop", a_play, 0);
        @(negedge newclk);
        chk("sb_drain", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
